// File: rtl/vending_pkg.sv
// Shared constants, state encoding and coin decoding for the newspaper vending controller.
package vending_pkg;

  localparam int unsigned COIN_W = 3;
  localparam int unsigned VAL_W  = 6;

  localparam logic [COIN_W-1:0] COIN_NONE = 3'b000;
  localparam logic [COIN_W-1:0] COIN_5    = 3'b001;
  localparam logic [COIN_W-1:0] COIN_10   = 3'b010;
  localparam logic [COIN_W-1:0] COIN_20   = 3'b011;
  localparam logic [COIN_W-1:0] COIN_50   = 3'b100;

  localparam logic [VAL_W-1:0] VAL_5  = 6'd5;
  localparam logic [VAL_W-1:0] VAL_10 = 6'd10;
  localparam logic [VAL_W-1:0] VAL_20 = 6'd20;
  localparam logic [VAL_W-1:0] VAL_50 = 6'd50;
  localparam logic [VAL_W-1:0] PRICE  = 6'd15;

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S5    = 3'd1,
    S10   = 3'd2,
    PAY5  = 3'd3,
    PAY10 = 3'd4
  } state_t;

  // Unit value of a coin code; none and invalid codes are worth zero.
  function automatic logic [VAL_W-1:0] coin_value(input logic [COIN_W-1:0] code);
    case (code)
      COIN_5:  coin_value = VAL_5;
      COIN_10: coin_value = VAL_10;
      COIN_20: coin_value = VAL_20;
      COIN_50: coin_value = VAL_50;
      default: coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine.sv
// Coin-accumulating vend controller: one vend pulse per 15 units, greedy change pulses,
// and a single follow-up payout cycle when the change needs a second coin of one denomination.
module vending_machine
  import vending_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [COIN_W-1:0] coin,
  output logic              nw_pa,
  output logic              ret5,
  output logic              ret10,
  output logic              ret20
);

  state_t state_q, state_d;
  logic   nw_pa_d, ret5_d, ret10_d, ret20_d;
  logic [VAL_W-1:0] credit, value, sum, rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
      nw_pa   <= 1'b0;
      ret5    <= 1'b0;
      ret10   <= 1'b0;
      ret20   <= 1'b0;
    end else begin
      state_q <= state_d;
      nw_pa   <= nw_pa_d;
      ret5    <= ret5_d;
      ret10   <= ret10_d;
      ret20   <= ret20_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nw_pa_d = 1'b0;
    ret5_d  = 1'b0;
    ret10_d = 1'b0;
    ret20_d = 1'b0;
    rem     = '0;
    value   = coin_value(coin);

    case (state_q)
      S5:      credit = VAL_5;
      S10:     credit = VAL_10;
      default: credit = '0;
    endcase
    sum = credit + value;

    case (state_q)
      // Coins arriving during payout are dropped on purpose.
      PAY5: begin
        ret5_d  = 1'b1;
        state_d = S0;
      end
      PAY10: begin
        ret10_d = 1'b1;
        state_d = S0;
      end
      default: begin
        if (value != '0) begin
          if (sum >= PRICE) begin
            nw_pa_d = 1'b1;
            rem     = sum - PRICE;
            if (rem >= VAL_20) begin
              ret20_d = 1'b1;
              rem     = rem - VAL_20;
            end
            if (rem >= VAL_10) begin
              ret10_d = 1'b1;
              rem     = rem - VAL_10;
            end
            if (rem >= VAL_5) begin
              ret5_d = 1'b1;
              rem    = rem - VAL_5;
            end
            // Greedy leaves at most one extra 5 or 10 still owed.
            if (rem == VAL_10)     state_d = PAY10;
            else if (rem == VAL_5) state_d = PAY5;
            else                   state_d = S0;
          end else begin
            state_d = (sum == VAL_10) ? S10 : S5;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed, table-driven bench for vending_machine with hand-written reset/payout sequences.
module tb_vending_machine;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] coin;
  logic       nw_pa, ret5, ret10, ret20;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] c;
    logic [3:0] exp;   // {nw_pa, ret20, ret10, ret5}
    string      name;
  } vec_t;

  vec_t vecs[$];

  vending_machine dut (
    .clk   (clk),
    .rst   (rst),
    .coin  (coin),
    .nw_pa (nw_pa),
    .ret5  (ret5),
    .ret10 (ret10),
    .ret20 (ret20)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [3:0] exp, input string name);
    logic [3:0] act;
    act = {nw_pa, ret20, ret10, ret5};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {nw,r20,r10,r5}=%b expected %b", name, act, exp);
    end
  endtask

  // Present a coin for one edge, then check the registered outputs just after it.
  task automatic step(input logic [2:0] c, input logic [3:0] exp, input string name);
    coin = c;
    @(posedge clk);
    #1;
    check(exp, name);
  endtask

  task automatic add(input logic [2:0] c, input logic [3:0] exp, input string name);
    vec_t v;
    v.c = c; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    // Sequential table; each entry continues from the state left by the previous one.
    add(3'b000, 4'b0000, "idle");
    add(3'b001, 4'b0000, "s0+5");
    add(3'b010, 4'b1000, "s5+10 vend");
    add(3'b010, 4'b0000, "s0+10");
    add(3'b001, 4'b1000, "s10+5 vend");
    add(3'b010, 4'b0000, "s0+10 b");
    add(3'b010, 4'b1001, "s10+10 vend r5");
    add(3'b001, 4'b0000, "s0+5 b");
    add(3'b011, 4'b1010, "s5+20 vend r10");
    add(3'b010, 4'b0000, "s0+10 c");
    add(3'b011, 4'b1011, "s10+20 vend r10 r5");
    add(3'b100, 4'b1111, "s0+50 vend all");
    add(3'b000, 4'b0000, "idle after 50");
    add(3'b011, 4'b1001, "s0+20 vend r5");
    add(3'b010, 4'b0000, "s0+10 d");
    add(3'b100, 4'b1111, "s10+50 vend all");
    add(3'b000, 4'b0010, "pay10 r10");
    add(3'b000, 4'b0000, "idle after pay10");
    add(3'b001, 4'b0000, "s0+5 c");
    add(3'b100, 4'b1111, "s5+50 vend all");
    add(3'b010, 4'b0001, "pay5 r5 coin ignored");
    add(3'b001, 4'b0000, "s0+5 after pay");
    add(3'b010, 4'b1000, "s5 confirmed vend");
    add(3'b001, 4'b0000, "held 5 edge1");
    add(3'b001, 4'b0000, "held 5 edge2");
    add(3'b001, 4'b1000, "held 5 edge3 vend");
    add(3'b001, 4'b0000, "held 5 edge4");
    add(3'b001, 4'b0000, "held 5 edge5");
    add(3'b001, 4'b1000, "s10 after held vend");
    add(3'b111, 4'b0000, "invalid 111 s0");
    add(3'b001, 4'b0000, "s0+5 d");
    add(3'b101, 4'b0000, "invalid 101 s5");
    add(3'b110, 4'b0000, "invalid 110 s5");
    add(3'b111, 4'b0000, "invalid 111 s5");
    add(3'b001, 4'b0000, "s5+5");
    add(3'b001, 4'b1000, "s10 kept vend");

    // Reset held with a coin present: nothing may be credited or pulsed.
    rst  = 1'b1;
    coin = 3'b001;
    #1;
    check(4'b0000, "reset async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check(4'b0000, "reset held coin");
    end
    rst = 1'b0;
    step(3'b000, 4'b0000, "post reset idle");
    step(3'b010, 4'b0000, "post reset s0+10");
    step(3'b001, 4'b1000, "post reset s10+5");

    foreach (vecs[i]) step(vecs[i].c, vecs[i].exp, vecs[i].name);

    // Asynchronous reset clears a live vend pulse without waiting for a clock.
    step(3'b011, 4'b1001, "vend before async rst");
    rst = 1'b1;
    #1;
    check(4'b0000, "async rst clears pulse");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(3'b000, 4'b0000, "after async rst idle");

    // Reset during PAY10 abandons the owed 10.
    step(3'b010, 4'b0000, "pre pay10 s0+10");
    step(3'b100, 4'b1111, "pre pay10 vend");
    coin = 3'b000;
    rst  = 1'b1;
    #1;
    check(4'b0000, "rst in pay10 immediate");
    @(posedge clk);
    #1;
    check(4'b0000, "rst in pay10 no r10");
    rst = 1'b0;
    step(3'b000, 4'b0000, "after pay10 rst idle");
    step(3'b001, 4'b0000, "after pay10 rst s0+5");
    step(3'b010, 4'b1000, "after pay10 rst vend");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
